onecount_stream: RTL
====================

Name: onecount_stream

Overview:
- Pipelined, streaming successor to the 16-bit combinational ones-counter, parametrised in data width.
- Per word, the block either reports the number of set bits, or accumulates that count across a frame and reports one total when IN_LAST arrives.
- Valid/ready handshakes on both sides, saturating accumulator and a threshold compare.
- Sits between a data source (bus monitor, error-vector collector) and a statistics or interrupt unit.

Parameters:
- DATA_W, 16, input word width in bits (>= 2).
- ACC_W, 16, width of COUNT and the frame accumulator; must be >= CW, where CW = $clog2(DATA_W+1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- DATA  input  DATA_W  input word.
- IN_VALID  input  1  DATA, IN_LAST and MODE are valid.
- IN_READY  output  1  block accepts the word this cycle.
- IN_LAST  input  1  word closes the current frame (MODE=1 only).
- MODE  input  1  0 = per-word count, 1 = frame accumulate; sampled per word at acceptance.
- THRESH  input  ACC_W  compare value; sampled at the output-register load.
- COUNT  output  ACC_W  result (per-word count zero-extended, or frame total).
- OUT_SAT  output  1  frame total saturated.
- OUT_GE  output  1  COUNT >= THRESH.
- OUT_VALID  output  1  COUNT/OUT_SAT/OUT_GE valid.
- OUT_READY  input  1  downstream accepts the result.

Behaviour:
- Reset (async, RST=1):
  - OUT_VALID=0, COUNT=0, OUT_SAT=0, OUT_GE=0.
  - Stage-1 valid=0; accumulator=0; sticky saturation flag=0.
  - A reset mid-frame discards the partial frame and any in-flight word.
- Pipeline control:
  - Two stages: S1 (popcount register) and S2 (output register).
  - adv = !OUT_VALID || OUT_READY; IN_READY = adv (combinational). A word is accepted when IN_VALID && IN_READY.
  - When adv=0 nothing moves: S1 and S2 hold, and COUNT/OUT_SAT/OUT_GE stay stable while OUT_VALID=1.
- S1, on adv:
  - s1_valid <= accept.
  - s1_cnt <= popcount(DATA) as a CW-bit value (0..DATA_W).
  - s1_mode <= MODE; s1_last <= IN_LAST.
- S2, on adv, when s1_valid:
  - s1_mode=0: COUNT <= zero-extended s1_cnt, OUT_SAT <= 0, OUT_VALID <= 1. Accumulator and sticky flag are untouched, so an open MODE=1 frame continues.
  - s1_mode=1, s1_last=0:
    - acc <= sat(acc + s1_cnt); sticky <= sticky | overflow.
    - No output: OUT_VALID <= 0.
  - s1_mode=1, s1_last=1:
    - COUNT <= sat(acc + s1_cnt); OUT_SAT <= sticky | overflow; OUT_VALID <= 1.
    - acc <= 0; sticky <= 0.
  - sat(x) clamps to 2^ACC_W-1; overflow means the unclamped sum exceeded 2^ACC_W-1.
- S2, on adv, when !s1_valid: OUT_VALID <= 0.
- OUT_GE <= (loaded COUNT value >= THRESH), unsigned, registered with COUNT.
- IN_LAST is ignored when MODE=0.
- Latency:
  - A MODE=0 word accepted at edge n appears with OUT_VALID=1 after edge n+1 (2-cycle latency).
  - A frame total appears 2 cycles after its IN_LAST word is accepted.
- Throughput: 1 word/cycle with OUT_READY held high.
- Simultaneous events:
  - Output consumed and new result loaded in the same cycle: allowed, no bubble.
  - A single-word frame (MODE=1, IN_LAST=1 on its first word) outputs that word's count.
- Boundaries:
  - DATA all zeros gives count 0; all ones gives DATA_W.
  - Accumulator never wraps.

Test Plan:
- MODE=0, OUT_READY=1, back-to-back DATA = 16'h5555, 16'hFFFF, 16'h0007, 16'h0000 -> COUNT 8, 16, 3, 0 on consecutive cycles starting 2 cycles after the first accept; IN_READY stays 1.
- MODE=1 frame 16'h07E0, 16'hFFE0, 16'hF03C (last), THRESH=20 -> a single output COUNT=25, OUT_GE=1, OUT_SAT=0; no OUT_VALID for the first two words.
- Backpressure: MODE=0 stream with OUT_READY=0 for 5 cycles -> OUT_VALID=1 with COUNT stable; IN_READY=0; after release the remaining results appear in order with none lost or duplicated.
- Saturation, ACC_W=5, DATA_W=16: MODE=1 frame of three 16'hFFFF (last on 3rd) -> COUNT=31, OUT_SAT=1; the next frame of one 16'h0003 -> COUNT=2, OUT_SAT=0.
- Interleave: open a MODE=1 frame with 16'h000F, then MODE=0 16'h00FF, then MODE=1 16'h0001 (last) -> outputs COUNT=8 (per-word), then COUNT=5 (frame).
- Assert RST after two MODE=1 words of a frame -> outputs clear immediately; a new frame of 16'hC00F (last) -> COUNT=6.

Source files
------------

// File: rtl/onecount_stream.sv
// Streaming ones-counter: per-word popcount or saturating per-frame total, 2-cycle latency.
// Backpressure: IN_READY = !OUT_VALID || OUT_READY; on a stall both stages freeze and outputs hold.
module onecount_stream #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_LAST,
    input  logic              MODE,
    input  logic [ACC_W-1:0]  THRESH,
    output logic [ACC_W-1:0]  COUNT,
    output logic              OUT_SAT,
    output logic              OUT_GE,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int SW = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic              s1_valid_q, s1_valid_d;
    logic [CW-1:0]     s1_cnt_q, s1_cnt_d;
    logic              s1_mode_q, s1_mode_d;
    logic              s1_last_q, s1_last_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic [ACC_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic              ge_q, ge_d;
    logic              out_valid_q, out_valid_d;

    logic              adv;
    logic [CW-1:0]     pop_cnt;
    logic [SW-1:0]     sum_full;
    logic              overflow;
    logic [ACC_W-1:0]  sum_sat;

    assign adv      = !out_valid_q || OUT_READY;
    assign IN_READY = adv;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pop_cnt = pop_cnt + CW'(DATA[i]);
        end
    end

    // One extra bit on the sum exposes overflow before clamping.
    assign sum_full = {1'b0, acc_q} + SW'(s1_cnt_q);
    assign overflow = sum_full[ACC_W];
    assign sum_sat  = overflow ? ACC_MAX : sum_full[ACC_W-1:0];

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_cnt_d    = s1_cnt_q;
        s1_mode_d   = s1_mode_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        count_d     = count_q;
        sat_d       = sat_q;
        ge_d        = ge_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            s1_valid_d  = IN_VALID;
            s1_cnt_d    = pop_cnt;
            s1_mode_d   = MODE;
            s1_last_d   = IN_LAST;
            out_valid_d = 1'b0;
            if (s1_valid_q) begin
                if (!s1_mode_q) begin
                    // Per-word results leave any open frame untouched.
                    count_d     = ACC_W'(s1_cnt_q);
                    sat_d       = 1'b0;
                    ge_d        = (ACC_W'(s1_cnt_q) >= THRESH);
                    out_valid_d = 1'b1;
                end else if (!s1_last_q) begin
                    acc_d    = sum_sat;
                    sticky_d = sticky_q | overflow;
                end else begin
                    count_d     = sum_sat;
                    sat_d       = sticky_q | overflow;
                    ge_d        = (sum_sat >= THRESH);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_cnt_q    <= '0;
            s1_mode_q   <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            ge_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cnt_q    <= s1_cnt_d;
            s1_mode_q   <= s1_mode_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            ge_q        <= ge_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign COUNT     = count_q;
    assign OUT_SAT   = sat_q;
    assign OUT_GE    = ge_q;
    assign OUT_VALID = out_valid_q;
endmodule
